regfile_mp: RTL and testbench

- Parametrised multi-port integer register file with write-to-read bypass and a pending-write scoreboard.
- Successor to the single-write, two-read register file in the decode stage; targets dual-issue and wider-datapath configurations.
- Read ports are combinational with same-cycle bypass. Writes and scoreboard updates are synchronous.
- Sits between decode (read, issue) and writeback (write, retire).

---
 rtl/regfile_mp_pkg.sv | 11 +
 rtl/regfile_mp_if.sv | 30 +++
 rtl/regfile_scoreboard.sv | 46 ++++
 rtl/regfile_mp.sv | 70 +++++++
 tb/tb_regfile_mp.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared defaults, the zero-register index and the port-slice helper
package regfile_mp_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = 5;
    localparam int REG_ZERO  = 0;

    function automatic int slot_lsb(input int p, input int w);
        return p * w;
    endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: decode/writeback bundle of the multi-port register file
interface regfile_mp_if
    import regfile_mp_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int AW     = AW_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
);
    logic [NUM_RD*AW-1:0]   rd_idx;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic [NUM_WR-1:0]      wr_en;
    logic [NUM_WR*AW-1:0]   wr_idx;
    logic [NUM_WR*XLEN-1:0] wr_data;
    logic                   iss_valid;
    logic [AW-1:0]          iss_rd;
    logic                   flush;
    logic [AW:0]            busy_cnt;

    modport master (
        output rd_idx, wr_en, wr_idx, wr_data, iss_valid, iss_rd, flush,
        input  rd_data, rd_busy, busy_cnt
    );
    modport slave (
        input  rd_idx, wr_en, wr_idx, wr_data, iss_valid, iss_rd, flush,
        output rd_data, rd_busy, busy_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write busy bits with flush/clear/set priority and registered popcount
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int AW       = AW_DEF,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    input  logic                 flush,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_idx,
    output logic [NREGS-1:0]     busy,
    output logic [AW:0]          busy_cnt
);
    localparam bit ZR = ZERO_REG != 0;
    localparam logic [AW-1:0] Z = AW'(REG_ZERO);

    logic [NREGS-1:0] busy_nxt;
    logic [AW:0]      cnt_nxt;

    // a new producer issuing this cycle supersedes any retiring one or a flush
    always_comb begin
        busy_nxt = flush ? '0 : busy;
        for (int w = 0; w < NUM_WR; w++)
            if (wr_en[w]) busy_nxt[wr_idx[slot_lsb(w, AW) +: AW]] = 1'b0;
        if (iss_valid && !(ZR && iss_rd == Z)) busy_nxt[iss_rd] = 1'b1;
        cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++)
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-to-read bypass and pending-write scoreboard
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int AW       = AW_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1
) (
    input logic        clk,
    input logic        rst_n,
    regfile_mp_if.slave bus
);
    localparam bit ZR = ZERO_REG != 0;
    localparam logic [AW-1:0] Z = AW'(REG_ZERO);

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] busy;

    regfile_scoreboard #(
        .NREGS(NREGS), .AW(AW), .NUM_WR(NUM_WR), .ZERO_REG(ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_valid(bus.iss_valid),
        .iss_rd   (bus.iss_rd),
        .flush    (bus.flush),
        .wr_en    (bus.wr_en),
        .wr_idx   (bus.wr_idx),
        .busy     (busy),
        .busy_cnt (bus.busy_cnt)
    );

    // later ports overwrite earlier ones, so the highest-numbered port wins a collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++)
                if (bus.wr_en[w] && !(ZR && bus.wr_idx[slot_lsb(w, AW) +: AW] == Z))
                    mem[bus.wr_idx[slot_lsb(w, AW) +: AW]] <= bus.wr_data[slot_lsb(w, XLEN) +: XLEN];
        end
    end

    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            logic [AW-1:0]   idx;
            logic [XLEN-1:0] d;
            logic            hit;
            idx = bus.rd_idx[slot_lsb(p, AW) +: AW];
            d   = mem[idx];
            hit = 1'b0;
            for (int w = 0; w < NUM_WR; w++)
                if (bus.wr_en[w] && bus.wr_idx[slot_lsb(w, AW) +: AW] == idx) begin
                    d   = bus.wr_data[slot_lsb(w, XLEN) +: XLEN];
                    hit = 1'b1;
                end
            if (ZR && idx == Z) begin
                d   = '0;
                hit = 1'b1;
            end
            bus.rd_data[slot_lsb(p, XLEN) +: XLEN] = d;
            bus.rd_busy[p] = busy[idx] && !hit;
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed checks of regfile_mp against an array-based model
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;

    logic [31:0] m_mem [32];
    bit          m_busy [32];

    regfile_mp_if #(.XLEN(32), .NREGS(32), .AW(5), .NUM_RD(2), .NUM_WR(2)) bus();

    regfile_mp #(
        .XLEN(32), .NREGS(32), .AW(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [4:0] widx(input int w);
        return w == 0 ? bus.wr_idx[4:0] : bus.wr_idx[9:5];
    endfunction

    function automatic logic [31:0] wdat(input int w);
        return w == 0 ? bus.wr_data[31:0] : bus.wr_data[63:32];
    endfunction

    function automatic bit wr_hit(input logic [4:0] i);
        return (bus.wr_en[0] && widx(0) == i) || (bus.wr_en[1] && widx(1) == i);
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] i);
        if (i == 0) return 32'h0;
        if (bus.wr_en[1] && widx(1) == i) return wdat(1);
        if (bus.wr_en[0] && widx(0) == i) return wdat(0);
        return m_mem[i];
    endfunction

    function automatic int exp_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic idle();
        bus.wr_en = '0;
        bus.wr_idx = '0;
        bus.wr_data = '0;
        bus.iss_valid = 1'b0;
        bus.iss_rd = '0;
        bus.flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] r);
        idle();
        bus.iss_valid = 1'b1;
        bus.iss_rd = r;
        tick();
    endtask

    // model: storage and busy bits updated from the rules, cleared by async reset
    initial begin
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = '0;
            m_busy[i] = 1'b0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 32; i++) begin
                    m_mem[i] = '0;
                    m_busy[i] = 1'b0;
                end
            end else begin
                for (int w = 0; w < 2; w++)
                    if (bus.wr_en[w] && widx(w) != 0) m_mem[widx(w)] = wdat(w);
                if (bus.flush) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
                for (int w = 0; w < 2; w++)
                    if (bus.wr_en[w]) m_busy[widx(w)] = 1'b0;
                if (bus.iss_valid && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            logic [4:0] i;
            i = p == 0 ? bus.rd_idx[4:0] : bus.rd_idx[9:5];
            chk($sformatf("cyc_rd_data%0d", p), 64'(p == 0 ? bus.rd_data[31:0] : bus.rd_data[63:32]), 64'(exp_data(i)));
            chk($sformatf("cyc_rd_busy%0d", p), 64'(bus.rd_busy[p]), 64'(i != 0 && m_busy[i] && !wr_hit(i)));
        end
        chk("cyc_busy_cnt", 64'(bus.busy_cnt), 64'(exp_cnt()));
    end

    initial begin
        idle();
        bus.rd_idx = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_rd_data", 64'(bus.rd_data), 64'h0);
        chk("rst_rd_busy", 64'(bus.rd_busy), 64'h0);
        chk("rst_busy_cnt", 64'(bus.busy_cnt), 64'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus.rd_idx = {5'(31 - i), 5'(i)};
            #1 chk("rst_all_zero", 64'(bus.rd_data), 64'h0);
        end
        tick();

        idle();
        bus.wr_en = 2'b01;
        bus.wr_idx = {5'd0, 5'd5};
        bus.wr_data = {32'h0, 32'hDEADBEEF};
        bus.rd_idx = {5'd0, 5'd5};
        #1 chk("bypass_x5", 64'(bus.rd_data[31:0]), 64'hDEADBEEF);
        tick();
        idle();
        #1 chk("stored_x5", 64'(bus.rd_data[31:0]), 64'hDEADBEEF);
        bus.wr_en = 2'b01;
        bus.wr_idx = {5'd0, 5'd0};
        bus.wr_data = {32'h0, 32'h1234};
        bus.rd_idx = {5'd5, 5'd0};
        #1 chk("x0_write_bypass", 64'(bus.rd_data[31:0]), 64'h0);
        tick();
        idle();
        #1 chk("x0_after_write", 64'(bus.rd_data[31:0]), 64'h0);

        bus.wr_en = 2'b11;
        bus.wr_idx = {5'd7, 5'd7};
        bus.wr_data = {32'h22, 32'h11};
        bus.rd_idx = {5'd7, 5'd7};
        #1 chk("collide_bypass", 64'(bus.rd_data), {32'h22, 32'h22});
        tick();
        idle();
        #1 chk("collide_stored", 64'(bus.rd_data[63:32]), 64'h22);

        bus.rd_idx = {5'd4, 5'd3};
        issue(5'd3);
        chk("sb_cnt1", 64'(bus.busy_cnt), 64'd1);
        chk("sb_busy_x3", 64'(bus.rd_busy[0]), 64'd1);
        issue(5'd4);
        idle();
        chk("sb_cnt2", 64'(bus.busy_cnt), 64'd2);
        bus.wr_en = 2'b01;
        bus.wr_idx = {5'd0, 5'd3};
        bus.wr_data = {32'h0, 32'hABC};
        #1 chk("wb_x3_busy", 64'(bus.rd_busy[0]), 64'd0);
        chk("wb_x3_data", 64'(bus.rd_data[31:0]), 64'hABC);
        chk("wb_x4_busy", 64'(bus.rd_busy[1]), 64'd1);
        tick();
        idle();
        chk("wb_cnt1", 64'(bus.busy_cnt), 64'd1);

        bus.rd_idx = {5'd0, 5'd9};
        issue(5'd9);
        chk("x9_cnt2", 64'(bus.busy_cnt), 64'd2);
        idle();
        bus.iss_valid = 1'b1;
        bus.iss_rd = 5'd9;
        bus.wr_en = 2'b10;
        bus.wr_idx = {5'd9, 5'd0};
        bus.wr_data = {32'h99, 32'h0};
        tick();
        idle();
        #1 chk("x9_set_wins_busy", 64'(bus.rd_busy[0]), 64'd1);
        chk("x9_set_wins_cnt", 64'(bus.busy_cnt), 64'd2);
        issue(5'd0);
        chk("x0_issue_cnt", 64'(bus.busy_cnt), 64'd2);

        issue(5'd1);
        issue(5'd2);
        issue(5'd3);
        chk("pre_flush_cnt", 64'(bus.busy_cnt), 64'd5);
        idle();
        bus.flush = 1'b1;
        bus.iss_valid = 1'b1;
        bus.iss_rd = 5'd8;
        tick();
        idle();
        bus.rd_idx = {5'd3, 5'd8};
        #1 chk("flush_cnt", 64'(bus.busy_cnt), 64'd1);
        chk("flush_busy", 64'(bus.rd_busy), 64'b01);

        for (int c = 0; c < 400; c++) begin
            bus.wr_en = 2'($urandom);
            bus.wr_idx = 10'($urandom);
            bus.wr_data = {$urandom, $urandom};
            bus.iss_valid = 1'($urandom_range(0, 2) != 0);
            bus.iss_rd = 5'($urandom);
            bus.flush = $urandom_range(0, 31) == 0;
            bus.rd_idx = $urandom_range(0, 3) == 0 ? {bus.wr_idx[9:5], bus.wr_idx[4:0]} : 10'($urandom);
            tick();
        end

        idle();
        bus.iss_valid = 1'b1;
        bus.iss_rd = 5'd12;
        tick();
        idle();
        bus.rd_idx = {5'd7, 5'd5};
        #2 rst_n = 1'b0;
        #1 chk("async_rst_cnt", 64'(bus.busy_cnt), 64'd0);
        chk("async_rst_data", 64'(bus.rd_data), 64'h0);
        bus.rd_idx = {5'd9, 5'd12};
        #1 chk("async_rst_busy", 64'(bus.rd_busy), 64'h0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
